uart_echo_responder: RTL

//  Far-end responder for the UART byte link: deserialises 8N1 frames on rx, reports each

---
 rtl/uart_echo_responder_pkg.sv | 12 +
 rtl/uart_echo_responder_if.sv | 23 ++
 rtl/uart_echo_responder_sync_fifo.sv | 50 +++++
 rtl/uart_echo_responder.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/uart_echo_responder_pkg.sv
// rtl/uart_echo_responder_pkg.sv - shared constants and FSM state encoding for the UART echo responder
package uart_echo_responder_pkg;
   localparam int DATA_BITS            = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 868;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_t;
endpackage

// File: rtl/uart_echo_responder_if.sv
// rtl/uart_echo_responder_if.sv - serial lines, echo control and receive reporting of the echo responder
interface uart_echo_responder_if;
   import uart_echo_responder_pkg::*;

   logic                 rx;
   logic                 echo_en;
   logic                 tx;
   logic [DATA_BITS-1:0] data_out;
   logic                 data_valid;
   logic                 frame_err;
   logic                 overflow;
   logic                 tx_busy;

   modport master (
      output rx, echo_en,
      input  tx, data_out, data_valid, frame_err, overflow, tx_busy
   );

   modport slave (
      input  rx, echo_en,
      output tx, data_out, data_valid, frame_err, overflow, tx_busy
   );
endinterface

// File: rtl/uart_echo_responder_sync_fifo.sv
// rtl/uart_echo_responder_sync_fifo.sv - single-clock FIFO with registered read, accepts push when full if popped
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Extra pointer bit separates full from empty when the index bits match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         pop_data <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr   <= rd_ptr + 1'b1;
            pop_data <= mem[rd_ptr[AW-1:0]];
         end
      end
   end
endmodule

// File: rtl/uart_echo_responder.sv
// rtl/uart_echo_responder.sv - 8N1 receiver that reports each good byte and echoes it back on tx
module uart_echo_responder
   import uart_echo_responder_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   uart_echo_responder_if.slave   bus
);
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

   logic                 rx_meta, rx_sync, rx_prev;
   uart_state_t          rx_state, tx_state;
   logic [CNT_W-1:0]     rx_cnt, tx_cnt;
   logic [BIT_W-1:0]     rx_bit, tx_bit;
   logic [DATA_BITS-1:0] rx_shift, tx_shift, fifo_data, data_out_r;
   logic                 data_valid_r, frame_err_r, overflow_r, tx_r;
   logic                 rx_fall, push, pop, fifo_full, fifo_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= bus.rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   assign rx_fall = rx_prev && !rx_sync;
   assign push    = (rx_state == ST_STOP) && (rx_cnt == BIT_LAST) && rx_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state     <= ST_IDLE;
         rx_cnt       <= '0;
         rx_bit       <= '0;
         rx_shift     <= '0;
         data_out_r   <= '0;
         data_valid_r <= 1'b0;
         frame_err_r  <= 1'b0;
      end else begin
         data_valid_r <= 1'b0;
         frame_err_r  <= 1'b0;
         case (rx_state)
            ST_IDLE: begin
               rx_cnt <= '0;
               if (rx_fall) rx_state <= ST_START;
            end
            ST_START: begin
               // Mid-start resample rejects glitches shorter than half a bit.
               if (rx_cnt == HALF_LAST) begin
                  rx_cnt   <= '0;
                  rx_bit   <= '0;
                  rx_state <= rx_sync ? ST_IDLE : ST_DATA;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            ST_DATA: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_cnt   <= '0;
                  rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
                  rx_bit   <= rx_bit + 1'b1;
                  if (rx_bit == LAST_BIT) rx_state <= ST_STOP;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            ST_STOP: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_cnt   <= '0;
                  rx_state <= rx_fall ? ST_START : ST_IDLE;
                  if (rx_sync) begin
                     data_out_r   <= rx_shift;
                     data_valid_r <= 1'b1;
                  end else begin
                     frame_err_r <= 1'b1;
                  end
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            default: rx_state <= ST_IDLE;
         endcase
      end
   end

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (rx_shift),
      .pop       (pop),
      .pop_data  (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             overflow_r <= 1'b0;
      else if (push && fifo_full && !pop)     overflow_r <= 1'b1;
   end

   // A new frame may begin from idle or straight out of the last stop-bit cycle.
   assign pop = ((tx_state == ST_IDLE) || ((tx_state == ST_STOP) && (tx_cnt == BIT_LAST)))
                && bus.echo_en && !fifo_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= ST_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         tx_r     <= 1'b1;
      end else begin
         case (tx_state)
            ST_IDLE: begin
               tx_cnt <= '0;
               if (pop) begin
                  tx_state <= ST_START;
                  tx_r     <= 1'b0;
               end
            end
            ST_START: begin
               // Registered FIFO read settles during the start bit; load it at its end.
               if (tx_cnt == BIT_LAST) begin
                  tx_cnt   <= '0;
                  tx_bit   <= '0;
                  tx_r     <= fifo_data[0];
                  tx_shift <= {1'b0, fifo_data[DATA_BITS-1:1]};
                  tx_state <= ST_DATA;
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            ST_DATA: begin
               if (tx_cnt == BIT_LAST) begin
                  tx_cnt <= '0;
                  if (tx_bit == LAST_BIT) begin
                     tx_r     <= 1'b1;
                     tx_state <= ST_STOP;
                  end else begin
                     tx_r     <= tx_shift[0];
                     tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
                     tx_bit   <= tx_bit + 1'b1;
                  end
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            ST_STOP: begin
               if (tx_cnt == BIT_LAST) begin
                  tx_cnt   <= '0;
                  tx_state <= pop ? ST_START : ST_IDLE;
                  tx_r     <= !pop;
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            default: tx_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.tx         = tx_r;
   assign bus.data_out   = data_out_r;
   assign bus.data_valid = data_valid_r;
   assign bus.frame_err  = frame_err_r;
   assign bus.overflow   = overflow_r;
   assign bus.tx_busy    = (tx_state != ST_IDLE);
endmodule
